// File: rtl/stopwatch_lap.sv
// BCD stopwatch with configurable seconds digits and a recallable lap buffer.
// Optional STOPWATCH_AUTOSTOP_EN saturates at all-9s and forces PAUSE instead of rolling over.
module stopwatch_lap #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned SEC_DIGITS = 2,
  parameter int unsigned LAP_DEPTH  = 4,
  localparam int unsigned ND        = SEC_DIGITS + 2,
  localparam int unsigned DW        = 4 * ND,
  localparam int unsigned CW        = $clog2(LAP_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_enable,
  input  logic          i_start_btn,
  input  logic          i_lap_btn,
  output logic [DW-1:0] o_display,
  output logic          o_running,
  output logic [CW-1:0] o_lap_cnt,
  output logic          o_lap_full,
  output logic [CW-1:0] o_view_idx,
  output logic          o_wrap,
  output logic          o_finish
);

  localparam int unsigned Ticks = CLK_FREQ / 100;
  localparam int unsigned PW    = $clog2(Ticks);

  typedef enum logic [1:0] {StIdle, StArmed, StRun, StPause} state_e;

  state_e        r_state;
  logic [PW-1:0] r_presc;
  logic [DW-1:0] r_time;
  logic [DW-1:0] r_lap [LAP_DEPTH];
  logic [CW-1:0] r_lap_cnt;
  logic [CW-1:0] r_view_idx;
  logic          r_running;
  logic          r_wrap;
  logic          r_finish;
  logic          r_start_q;
  logic          r_lap_q;

  logic          w_start_p;
  logic          w_lap_p;
  logic          w_full;
  logic          w_tick;
  logic          w_all9;
  logic [DW-1:0] w_time_inc;
  logic [DW-1:0] w_display;

  assign w_start_p = i_start_btn & ~r_start_q;
  assign w_lap_p   = i_lap_btn & ~r_lap_q;
  assign w_full    = (r_lap_cnt == CW'(LAP_DEPTH));
  assign w_tick    = (r_state == StRun) && (r_presc == PW'(Ticks - 1));

  // Ripple BCD increment; carry out of the top digit means the time was all 9s.
  always_comb begin
    logic carry;
    carry      = 1'b1;
    w_time_inc = r_time;
    for (int i = 0; i < int'(ND); i++) begin
      if (carry) begin
        if (r_time[4*i +: 4] == 4'd9) begin
          w_time_inc[4*i +: 4] = 4'd0;
        end else begin
          w_time_inc[4*i +: 4] = r_time[4*i +: 4] + 4'd1;
          carry                = 1'b0;
        end
      end
    end
    w_all9 = carry;
  end

  always_comb begin
    w_display = r_time;
    for (int i = 0; i < int'(LAP_DEPTH); i++) begin
      if (r_view_idx == CW'(i + 1)) w_display = r_lap[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_presc    <= '0;
      r_time     <= '0;
      for (int i = 0; i < int'(LAP_DEPTH); i++) r_lap[i] <= '0;
      r_lap_cnt  <= '0;
      r_view_idx <= '0;
      r_running  <= 1'b0;
      r_wrap     <= 1'b0;
      r_finish   <= 1'b0;
      r_start_q  <= 1'b0;
      r_lap_q    <= 1'b0;
    end else begin
      r_start_q <= i_start_btn;
      r_lap_q   <= i_lap_btn;
      r_finish  <= ~i_enable;
      r_wrap    <= 1'b0;
      // Mode switch off overrides everything, including presses this cycle.
      if (!i_enable || r_state == StIdle) begin
        r_state    <= i_enable ? StArmed : StIdle;
        r_presc    <= '0;
        r_time     <= '0;
        for (int i = 0; i < int'(LAP_DEPTH); i++) r_lap[i] <= '0;
        r_lap_cnt  <= '0;
        r_view_idx <= '0;
        r_running  <= 1'b0;
      end else begin
        unique case (r_state)
          StArmed: begin
            r_presc <= '0;
            r_time  <= '0;
            if (w_start_p) begin
              r_state   <= StRun;
              r_running <= 1'b1;
            end
          end
          StRun: begin
            if (w_start_p) begin
              r_state   <= StPause;
              r_running <= 1'b0;
            end else begin
              if (w_lap_p && !w_full) begin
                for (int i = 0; i < int'(LAP_DEPTH); i++) begin
                  if (r_lap_cnt == CW'(i)) r_lap[i] <= r_time;
                end
                r_lap_cnt <= r_lap_cnt + CW'(1);
              end
              if (w_tick) begin
                r_presc <= '0;
                r_wrap  <= w_all9;
`ifdef STOPWATCH_AUTOSTOP_EN
                if (w_all9) begin
                  r_state   <= StPause;
                  r_running <= 1'b0;
                end else begin
                  r_time <= w_time_inc;
                end
`else
                r_time <= w_time_inc;
`endif
              end else begin
                r_presc <= r_presc + PW'(1);
              end
            end
          end
          StPause: begin
            if (w_start_p) begin
              r_state    <= StRun;
              r_running  <= 1'b1;
              r_view_idx <= '0;
            end else if (w_lap_p) begin
              r_view_idx <= (r_view_idx == r_lap_cnt) ? '0 : r_view_idx + CW'(1);
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign o_display  = w_display;
  assign o_running  = r_running;
  assign o_lap_cnt  = r_lap_cnt;
  assign o_lap_full = w_full;
  assign o_view_idx = r_view_idx;
  assign o_wrap     = r_wrap;
  assign o_finish   = r_finish;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap: CLK_FREQ=400 (tick every 4 clocks), 2 seconds digits, 2 laps.
module tb_stopwatch_lap;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start_btn;
  logic        lap_btn;
  logic [15:0] display;
  logic        running;
  logic [1:0]  lap_cnt;
  logic        lap_full;
  logic [1:0]  view_idx;
  logic        wrap;
  logic        finish;

  int n_cmp = 0;
  int n_err = 0;

  stopwatch_lap #(
    .CLK_FREQ  (400),
    .SEC_DIGITS(2),
    .LAP_DEPTH (2)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .i_enable   (enable),
    .i_start_btn(start_btn),
    .i_lap_btn  (lap_btn),
    .o_display  (display),
    .o_running  (running),
    .o_lap_cnt  (lap_cnt),
    .o_lap_full (lap_full),
    .o_view_idx (view_idx),
    .o_wrap     (wrap),
    .o_finish   (finish)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press seen at the next rising edge; one idle edge follows so presses never merge.
  task automatic press_start();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_lap();
    lap_btn = 1'b1;
    @(negedge clk);
    lap_btn = 1'b0;
    @(negedge clk);
  endtask

  // Reset, arm, start. Returns one edge after the RUN transition (elapsed k = 1).
  task automatic restart();
    reset     = 1'b1;
    enable    = 1'b0;
    start_btn = 1'b0;
    lap_btn   = 1'b0;
    wait_cycles(2);
    reset  = 1'b0;
    enable = 1'b1;
    wait_cycles(1);
    press_start();
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    start_btn = 1'b0;
    lap_btn   = 1'b0;
    wait_cycles(3);
    check_eq("rst_display", 32'(display), 32'h0);
    check_eq("rst_running", 32'(running), 32'h0);
    check_eq("rst_lap_cnt", 32'(lap_cnt), 32'h0);
    check_eq("rst_view", 32'(view_idx), 32'h0);
    check_eq("rst_wrap", 32'(wrap), 32'h0);
    check_eq("rst_finish", 32'(finish), 32'h0);

    // Basic counting and first-tick latency
    restart();
    wait_cycles(2);
    check_eq("k3_display", 32'(display), 32'h0000);
    wait_cycles(1);
    check_eq("k4_display", 32'(display), 32'h0001);
    wait_cycles(396);
    check_eq("k400_display", 32'(display), 32'h0100);
    check_eq("k400_running", 32'(running), 32'h1);
    check_eq("run_finish", 32'(finish), 32'h0);

    // Pause at 00.37, hold, resume
    restart();
    wait_cycles(147);
    check_eq("at37_display", 32'(display), 32'h0037);
    press_start();
    check_eq("pause_display", 32'(display), 32'h0037);
    check_eq("pause_running", 32'(running), 32'h0);
    wait_cycles(100);
    check_eq("hold_display", 32'(display), 32'h0037);
    press_start();
    check_eq("resume_running", 32'(running), 32'h1);
    wait_cycles(2);
    check_eq("resume3_display", 32'(display), 32'h0037);
    wait_cycles(1);
    check_eq("resume4_display", 32'(display), 32'h0038);

    // Laps at 00.05 and 00.12, third ignored, then recall
    restart();
    wait_cycles(19);
    press_lap();
    check_eq("lap1_cnt", 32'(lap_cnt), 32'h1);
    check_eq("lap1_full", 32'(lap_full), 32'h0);
    wait_cycles(26);
    press_lap();
    check_eq("lap2_cnt", 32'(lap_cnt), 32'h2);
    check_eq("lap2_full", 32'(lap_full), 32'h1);
    press_lap();
    check_eq("lap3_cnt", 32'(lap_cnt), 32'h2);
    check_eq("lap3_full", 32'(lap_full), 32'h1);
    wait_cycles(4);
    press_start();
    check_eq("recall_live", 32'(display), 32'h0014);
    check_eq("recall_view0", 32'(view_idx), 32'h0);
    press_lap();
    check_eq("recall_view1", 32'(view_idx), 32'h1);
    check_eq("recall_disp1", 32'(display), 32'h0005);
    press_lap();
    check_eq("recall_view2", 32'(view_idx), 32'h2);
    check_eq("recall_disp2", 32'(display), 32'h0012);
    press_lap();
    check_eq("recall_wrap_view", 32'(view_idx), 32'h0);
    check_eq("recall_wrap_disp", 32'(display), 32'h0014);

    // Rollover at 99.99
    restart();
    wait_cycles(39995);
    check_eq("max_display", 32'(display), 32'h9999);
    check_eq("max_wrap", 32'(wrap), 32'h0);
    wait_cycles(4);
`ifdef STOPWATCH_AUTOSTOP_EN
    check_eq("ovf_display", 32'(display), 32'h9999);
    check_eq("ovf_running", 32'(running), 32'h0);
`else
    check_eq("ovf_display", 32'(display), 32'h0000);
    check_eq("ovf_running", 32'(running), 32'h1);
`endif
    check_eq("ovf_wrap", 32'(wrap), 32'h1);
    wait_cycles(1);
    check_eq("ovf_wrap_next", 32'(wrap), 32'h0);

    // Start and lap in the same cycle: start wins
    restart();
    wait_cycles(9);
    start_btn = 1'b1;
    lap_btn   = 1'b1;
    wait_cycles(1);
    start_btn = 1'b0;
    lap_btn   = 1'b0;
    wait_cycles(1);
    check_eq("both_running", 32'(running), 32'h0);
    check_eq("both_lap_cnt", 32'(lap_cnt), 32'h0);

    // Lap on the 00.09 -> 00.10 tick stores 0009
    restart();
    wait_cycles(38);
    press_lap();
    check_eq("tick_lap_cnt", 32'(lap_cnt), 32'h1);
    check_eq("tick_lap_live", 32'(display), 32'h0010);
    press_start();
    press_lap();
    check_eq("tick_lap_entry", 32'(display), 32'h0009);

    // Mode switch off mid-run at 00.50
    restart();
    wait_cycles(99);
    press_lap();
    wait_cycles(98);
    check_eq("at50_display", 32'(display), 32'h0050);
    enable = 1'b0;
    wait_cycles(1);
    check_eq("off_display", 32'(display), 32'h0000);
    check_eq("off_lap_cnt", 32'(lap_cnt), 32'h0);
    check_eq("off_running", 32'(running), 32'h0);
    check_eq("off_finish", 32'(finish), 32'h1);

    // Asynchronous reset mid-run
    restart();
    wait_cycles(19);
    press_lap();
    wait_cycles(20);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_display", 32'(display), 32'h0000);
    check_eq("arst_running", 32'(running), 32'h0);
    check_eq("arst_lap_cnt", 32'(lap_cnt), 32'h0);
    check_eq("arst_finish", 32'(finish), 32'h0);
    wait_cycles(2);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
